// File: rtl/sgd_scheduler.sv
// Sequencer for the SGD engine: addresses the serial dataset load into sample memory,
// then issues one update request per row per epoch and flags completion.
module sgd_scheduler #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [$clog2(MAX_FEATURES+1)-1:0]     feat,
  input  logic [7:0]                            epoch,
  input  logic [ADDR_WIDTH-1:0]                 data_points,
  input  logic [3:0]                            learn_rate,
  input  logic                                  word_valid,
  input  logic                                  upd_done,
  output logic                                  wr_en,
  output logic [ADDR_WIDTH-1:0]                 wr_addr,
  output logic [$clog2(MAX_FEATURES+1)-1:0]     wr_lane,
  output logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic                                  upd_start,
  output logic [3:0]                            lr_shift,
  output logic [7:0]                            cur_epoch,
  output logic                                  busy,
  output logic                                  sgd_done
);

  localparam int LANE_W = $clog2(MAX_FEATURES + 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_row, w_row_next;
  logic [LANE_W-1:0]     r_lane, w_lane_next;
  logic [7:0]            r_ep, w_ep_next;
  logic [LANE_W-1:0]     r_feat;
  logic [7:0]            r_epoch;
  logic [ADDR_WIDTH-1:0] r_dp;
  logic [3:0]            r_lr;
  logic                  w_wr_en;
  logic                  w_upd_start;

  // Configuration is sampled throughout reset and frozen once it releases.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_LOAD;
      r_row   <= '0;
      r_lane  <= feat;
      r_ep    <= '0;
      r_feat  <= feat;
      r_epoch <= epoch;
      r_dp    <= data_points;
      r_lr    <= learn_rate;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_lane  <= w_lane_next;
      r_ep    <= w_ep_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row;
    w_lane_next  = r_lane;
    w_ep_next    = r_ep;
    w_wr_en      = 1'b0;
    w_upd_start  = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (word_valid) begin
          w_wr_en = 1'b1;
          if (r_lane == '0) begin
            w_lane_next = r_feat;
            if (r_row == r_dp) begin
              w_row_next   = '0;
              w_state_next = (r_epoch == 8'd0) ? S_DONE : S_ISSUE;
            end else begin
              w_row_next = r_row + ADDR_WIDTH'(1);
            end
          end else begin
            w_lane_next = r_lane - LANE_W'(1);
          end
        end
      end
      S_ISSUE: begin
        // Any upd_done seen alongside the request belongs to nothing and is dropped.
        w_upd_start  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (upd_done) begin
          if (r_row < r_dp) begin
            w_row_next   = r_row + ADDR_WIDTH'(1);
            w_state_next = S_ISSUE;
          end else if (r_ep == r_epoch - 8'd1) begin
            w_state_next = S_DONE;
          end else begin
            w_row_next   = '0;
            w_ep_next    = r_ep + 8'd1;
            w_state_next = S_ISSUE;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign wr_en     = w_wr_en & ~RST;
  assign wr_addr   = r_row;
  assign wr_lane   = r_lane;
  assign upd_start = w_upd_start;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign rd_addr   = busy ? r_row : '0;
  assign lr_shift  = r_lr;
  assign cur_epoch = r_ep;
  assign sgd_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_sgd_scheduler.sv
// Directed bench for sgd_scheduler: load addressing, loop counts, zero epochs,
// ignored handshakes, minimum latency and mid-run reset.
module tb_sgd_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  feat = 4'd0;
  logic [7:0]  epoch = 8'd0;
  logic [11:0] data_points = 12'd0;
  logic [3:0]  learn_rate = 4'd0;
  logic        word_valid = 1'b0;
  logic        upd_done = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [3:0]  wr_lane;
  logic [11:0] rd_addr;
  logic        upd_start;
  logic [3:0]  lr_shift;
  logic [7:0]  cur_epoch;
  logic        busy;
  logic        sgd_done;

  int checks = 0;
  int failures = 0;

  sgd_scheduler #(.ADDR_WIDTH(12), .MAX_FEATURES(15)) dut (
    .CLK(CLK), .RST(RST), .feat(feat), .epoch(epoch), .data_points(data_points),
    .learn_rate(learn_rate), .word_valid(word_valid), .upd_done(upd_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .rd_addr(rd_addr),
    .upd_start(upd_start), .lr_shift(lr_shift), .cur_epoch(cur_epoch),
    .busy(busy), .sgd_done(sgd_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] f, input logic [7:0] e,
                          input logic [11:0] dp, input logic [3:0] lr);
    RST = 1'b1; feat = f; epoch = e; data_points = dp; learn_rate = lr;
    word_valid = 1'b0; upd_done = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
    #1;
  endtask

  task automatic load_words(input int n);
    for (int k = 0; k < n; k++) begin
      word_valid = 1'b1;
      cyc();
    end
    word_valid = 1'b0;
    #1;
  endtask

  initial begin
    int starts;
    int wcnt;
    int n;
    int altbad;
    logic [3:0] exp_lane [4];
    logic [11:0] exp_row [4];
    exp_lane = '{4'd1, 4'd0, 4'd1, 4'd0};
    exp_row  = '{12'd0, 12'd0, 12'd1, 12'd1};

    // ---- Load addressing, reset values and ignored handshakes ----
    do_reset(4'd1, 8'd1, 12'd1, 4'd3);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_lane", 32'(wr_lane), 32'd1);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_upd_start", 32'(upd_start), 32'd0);
    chk("rst_cur_epoch", 32'(cur_epoch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sgd_done", 32'(sgd_done), 32'd0);
    chk("rst_lr_shift", 32'(lr_shift), 32'd3);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    #1;
    chk("load_updone_lane", 32'(wr_lane), 32'd1);
    chk("load_updone_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      word_valid = 1'b1;
      #1;
      chk($sformatf("t1_wr_en_%0d", k), 32'(wr_en), 32'd1);
      chk($sformatf("t1_wr_addr_%0d", k), 32'(wr_addr), 32'(exp_row[k]));
      chk($sformatf("t1_wr_lane_%0d", k), 32'(wr_lane), 32'(exp_lane[k]));
      cyc();
    end
    word_valid = 1'b0;
    #1;
    chk("t1_issue_start", 32'(upd_start), 32'd1);
    chk("t1_issue_rd", 32'(rd_addr), 32'd0);
    chk("t1_issue_busy", 32'(busy), 32'd1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    word_valid = 1'b1;
    #1;
    chk("t1_wait_start", 32'(upd_start), 32'd0);
    chk("t1_wait_busy", 32'(busy), 32'd1);
    chk("t1_wait_wr_en", 32'(wr_en), 32'd0);
    cyc();
    word_valid = 1'b0;
    #1;
    chk("t1_wait2_start", 32'(upd_start), 32'd0);
    chk("t1_wait2_rd", 32'(rd_addr), 32'd0);
    chk("t1_wait2_busy", 32'(busy), 32'd1);
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    #1;
    chk("t1_issue1_start", 32'(upd_start), 32'd1);
    chk("t1_issue1_rd", 32'(rd_addr), 32'd1);
    cyc();
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    #1;
    chk("t1_done", 32'(sgd_done), 32'd1);
    chk("t1_done_busy", 32'(busy), 32'd0);
    upd_done = 1'b1;
    word_valid = 1'b1;
    #1;
    chk("t1_done_wr_en", 32'(wr_en), 32'd0);
    cyc(); cyc();
    upd_done = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("t1_done_hold", 32'(sgd_done), 32'd1);
    chk("t1_done_start", 32'(upd_start), 32'd0);
    chk("t1_done_epoch", 32'(cur_epoch), 32'd0);

    // ---- Loop count: 7 rows x 25 epochs ----
    do_reset(4'd11, 8'd25, 12'd6, 4'd2);
    load_words(84);
    starts = 0;
    wcnt = 0;
    for (int c = 0; c < 2000; c++) begin
      upd_done = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) upd_done = 1'b1;
      end
      #1;
      if (sgd_done) break;
      if (upd_start) begin
        starts++;
        wcnt = 3;
      end
      cyc();
    end
    upd_done = 1'b0;
    #1;
    chk("t2_starts", 32'(starts), 32'd175);
    chk("t2_lr_shift", 32'(lr_shift), 32'd2);
    chk("t2_cur_epoch", 32'(cur_epoch), 32'd24);
    chk("t2_done", 32'(sgd_done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);

    // ---- Zero epochs: single word, straight to done ----
    do_reset(4'd0, 8'd0, 12'd0, 4'd5);
    chk("t3_rst_lane", 32'(wr_lane), 32'd0);
    word_valid = 1'b1;
    #1;
    chk("t3_wr_en", 32'(wr_en), 32'd1);
    chk("t3_wr_addr", 32'(wr_addr), 32'd0);
    chk("t3_wr_lane", 32'(wr_lane), 32'd0);
    cyc();
    word_valid = 1'b0;
    #1;
    starts = 0;
    for (int c = 0; c < 4; c++) begin
      if (upd_start) starts++;
      cyc();
    end
    chk("t3_done", 32'(sgd_done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_no_start", 32'(starts), 32'd0);

    // ---- Minimum latency: upd_done held high throughout training ----
    do_reset(4'd2, 8'd2, 12'd3, 4'd1);
    load_words(12);
    upd_done = 1'b1;
    starts = 0;
    altbad = 0;
    n = 0;
    while (n < 200) begin
      #1;
      if (sgd_done) break;
      if (upd_start) starts++;
      if (upd_start !== ((n % 2) == 0)) altbad++;
      n++;
      cyc();
    end
    upd_done = 1'b0;
    chk("t4_starts", 32'(starts), 32'd8);
    chk("t4_alternate", 32'(altbad), 32'd0);
    chk("t4_done_cycle", 32'(n), 32'd16);
    chk("t4_done", 32'(sgd_done), 32'd1);

    // ---- Mid-run reset during WAIT of epoch 3 ----
    do_reset(4'd0, 8'd5, 12'd1, 4'd4);
    load_words(2);
    n = 0;
    while (n < 200 && !(busy && !upd_start && cur_epoch == 8'd3)) begin
      upd_done = busy && !upd_start;
      cyc();
      upd_done = 1'b0;
      #1;
      n++;
    end
    chk("t5_reached_wait", 32'(cur_epoch), 32'd3);
    RST = 1'b1; feat = 4'd1; epoch = 8'd1; data_points = 12'd0; learn_rate = 4'd7;
    upd_done = 1'b1;
    cyc();
    RST = 1'b0;
    upd_done = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_wr_addr", 32'(wr_addr), 32'd0);
    chk("t5_cur_epoch", 32'(cur_epoch), 32'd0);
    chk("t5_sgd_done", 32'(sgd_done), 32'd0);
    chk("t5_wr_lane", 32'(wr_lane), 32'd1);
    chk("t5_lr_shift", 32'(lr_shift), 32'd7);
    for (int k = 0; k < 2; k++) begin
      word_valid = 1'b1;
      #1;
      chk($sformatf("t5_wr_en_%0d", k), 32'(wr_en), 32'd1);
      chk($sformatf("t5_wr_lane_%0d", k), 32'(wr_lane), 32'(1 - k));
      cyc();
    end
    word_valid = 1'b0;
    #1;
    chk("t5_issue", 32'(upd_start), 32'd1);
    chk("t5_issue_rd", 32'(rd_addr), 32'd0);
    cyc();
    upd_done = 1'b1;
    cyc();
    upd_done = 1'b0;
    #1;
    chk("t5_done", 32'(sgd_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sgd_scheduler.md
# sgd_scheduler

Control block for the SGD linear-regression engine. Tracks the serial dataset load: it counts deserialized 16-bit words and generates write addresses and feature lanes for the sample memory. It then runs the training loop, one update request per data point per epoch, and raises `sgd_done` when the final epoch completes. It sits between the serial deserializer, the sample memory and the gradient/update datapath inside `main`.

## Interface
- `ADDR_WIDTH`, 12, width of row address and data-point count
- `MAX_FEATURES`, 15, maximum feature index; lane counter width is 4 bits
- `CLK` in 1: single clock, rising edge
- `RST` in 1: synchronous, active-high reset
- `feat` in 4: highest feature index; each row holds feat+1 words (features plus y)
- `epoch` in 8: number of training epochs
- `data_points` in ADDR_WIDTH: highest row index; rows are 0..data_points
- `learn_rate` in 4: learning-rate shift amount
- `word_valid` in 1: one-cycle strobe from the deserializer, one full 16-bit word available
- `upd_done` in 1: one-cycle strobe from the update datapath, current sample finished
- `wr_en` out 1: sample memory write enable
- `wr_addr` out ADDR_WIDTH: row being written
- `wr_lane` out 4: word slot within the row
- `rd_addr` out ADDR_WIDTH: row presented to the update datapath
- `upd_start` out 1: one-cycle request to process `rd_addr`
- `lr_shift` out 4: latched learning rate
- `cur_epoch` out 8: current epoch index
- `busy` out 1: training loop active
- `sgd_done` out 1: training complete, held

## Operation
- States: LOAD, ISSUE, WAIT, DONE. Reset forces LOAD.
- Config capture: `feat`, `epoch`, `data_points` and `learn_rate` are registered on every cycle `RST` is high. They are frozen from the first cycle after reset. `lr_shift` shows the latched `learn_rate`.
- LOAD:
  - `wr_en` = `word_valid` (combinational). `wr_addr` = row counter; `wr_lane` = lane counter.
  - Lane counter starts at feat and decrements on each `word_valid`. Words arrive highest lane first.
  - At lane 0: lane reloads feat and row increments.
  - On the write of row = data_points, lane 0 (total (data_points+1)·(feat+1) words):
    - if epoch = 0, go to DONE
    - otherwise reset the row counter to 0 and go to ISSUE.
- ISSUE: `upd_start`=1 for exactly one cycle with `rd_addr` = row, then go to WAIT.
- WAIT: hold `rd_addr`. On `upd_done`:
  - if row < data_points: row+1, go to ISSUE
  - else if cur_epoch = epoch−1: go to DONE
  - else: row=0, cur_epoch+1, go to ISSUE.
- DONE: `sgd_done`=1 and `busy`=0. The state holds until `RST`.
- `busy`=1 exactly in ISSUE and WAIT.
- Ignored inputs:
  - `word_valid` outside LOAD: no write, no count.
  - `upd_done` outside WAIT.
  - `upd_done` asserted in the same cycle as `upd_start`.
- Counters are unsigned. data_points ≥ 0 and feat ≥ 0, so a single row of a single word is legal. No wrap-around beyond the configured limits.

## Timing
- Reset values: `wr_en`=0 (`word_valid` gated by RST), `wr_addr`=0, `wr_lane`=feat input, `rd_addr`=0, `upd_start`=0, `cur_epoch`=0, `busy`=0, `sgd_done`=0, `lr_shift`=learn_rate input.
- Write: zero-latency, same cycle as `word_valid`. Counters update on the following edge.
- Load → training: the last write cycle is followed by ISSUE on the next cycle.
- Per sample: ISSUE takes 1 cycle. WAIT takes ≥1 cycle, and `upd_done` is accepted no earlier than the cycle after `upd_start`. The minimum is 2 cycles per sample.
- Completion: `sgd_done` rises on the cycle after the last accepted `upd_done`.
- Reset mid-operation: return to LOAD with counters cleared on the next edge and config recaptured. Any pending `upd_done` is discarded.

## Test plan
- Load addressing: feat=1, data_points=1, 4 strobes → writes (row,lane) = (0,1),(0,0),(1,1),(1,0). ISSUE follows the 4th write; `rd_addr`=0.
- Loop count: feat=11, data_points=6, epoch=25, learn_rate=2, `upd_done` 3 cycles after each start → exactly 175 `upd_start` pulses and `lr_shift`=2. Final `cur_epoch`=24, then `sgd_done`=1 and `busy`=0.
- Zero epochs: epoch=0, data_points=0, feat=0, one strobe → one write at (0,0), then `sgd_done`=1 with no `upd_start`.
- Spurious handshakes: `upd_done` in ISSUE, in LOAD and in DONE, and `word_valid` during WAIT → no state, counter or write change.
- Minimum latency: `upd_done` on every cycle after each start, epoch=2, data_points=3 → 8 starts on alternate cycles, `sgd_done` 16 cycles after the first ISSUE.
- Mid-run reset: RST asserted in WAIT of epoch 3 → next cycle is LOAD with row 0, `cur_epoch`=0 and `busy`=0. A fresh load then restarts correctly.
